// File: rtl/register_writeback_buffer.sv
// In-order write buffer between execution units and the register file write port.
// Drains one entry per cycle and forwards still-queued results to operand lookups.
module register_writeback_buffer #(
  parameter int unsigned WORDSIZE  = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DROP_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_addr,
  input  logic [WORDSIZE-1:0]       in_data,
  input  logic                      wb_hold,
  output logic                      wb_en,
  output logic [4:0]                wb_addr,
  output logic [WORDSIZE-1:0]       wb_data,
  input  logic [4:0]                look_addr_a,
  input  logic [4:0]                look_addr_b,
  output logic                      hit_a,
  output logic                      hit_b,
  output logic [WORDSIZE-1:0]       fwd_a,
  output logic [WORDSIZE-1:0]       fwd_b,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]          addr_q  [DEPTH];
  logic [WORDSIZE-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;

  logic push_fire;
  logic drop;
  logic enq;
  logic pop;

  assign in_ready  = (count_q < CntW'(DEPTH));
  assign push_fire = in_valid & in_ready;
  // Writes to r0 complete the handshake but are discarded.
  assign drop      = (DROP_ZERO != 0) && (in_addr == 5'd0);
  assign enq       = push_fire & ~drop;
  assign wb_en     = (count_q != '0) & ~wb_hold;
  assign pop       = wb_en;
  assign count     = count_q;

  always_comb begin
    wb_addr = '0;
    wb_data = '0;
    if (count_q != '0) begin
      wb_addr = addr_q[rd_ptr_q];
      wb_data = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // enq and pop never target the same slot: that needs count 0 (no pop) or full (no enq).
      if (enq) begin
        addr_q[wr_ptr_q]  <= in_addr;
        data_q[wr_ptr_q]  <= in_data;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      unique case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (valid_q[idx]) begin
        if (addr_q[idx] == look_addr_a &&
            !((DROP_ZERO != 0) && (look_addr_a == 5'd0))) begin
          hit_a = 1'b1;
          fwd_a = data_q[idx];
        end
        if (addr_q[idx] == look_addr_b &&
            !((DROP_ZERO != 0) && (look_addr_b == 5'd0))) begin
          hit_b = 1'b1;
          fwd_b = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_writeback_buffer.sv
// Bench for register_writeback_buffer: queue-based scoreboard of expected register writes
// plus directed checks of occupancy, handshake and forwarding.
module tb_register_writeback_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [63:0] in_data;
  logic        wb_hold;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [4:0]  look_addr_a;
  logic [4:0]  look_addr_b;
  logic        hit_a;
  logic        hit_b;
  logic [63:0] fwd_a;
  logic [63:0] fwd_b;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;
  logic [68:0] exp_q[$];

  register_writeback_buffer #(
    .WORDSIZE (64),
    .DEPTH    (4),
    .DROP_ZERO(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wb_hold    (wb_hold),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .look_addr_a(look_addr_a),
    .look_addr_b(look_addr_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer: hold the request until an edge where in_ready was high.
  task automatic push(input logic [4:0] a, input logic [63:0] d);
    logic acc;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        done = 1'b1;
        if (a != 5'd0) exp_q.push_back({a, d});
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got no ready expected ready within 20 cycles");
    end
  endtask

  // Monitor: every cycle the DUT presents a write, it must match the oldest expected write.
  always @(negedge clk) begin
    logic [68:0] e;
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, wb_addr}, 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", {59'd0, wb_addr}, {59'd0, e[68:64]});
        check("wb_data", wb_data, e[63:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    wb_hold     = 1'b1;
    look_addr_a = '0;
    look_addr_b = '0;
    #1;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_wb_en", {63'd0, wb_en}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_fwd_a", fwd_a, 64'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    wb_hold = 1'b0;
    tick();

    // Single push appears on wb_* right after the accepting edge, gone after the next.
    push(5'd5, 64'hAA);
    check("t2_wb_en", {63'd0, wb_en}, 64'd1);
    check("t2_wb_addr", {59'd0, wb_addr}, 64'd5);
    check("t2_wb_data", wb_data, 64'hAA);
    check("t2_count1", {61'd0, count}, 64'd1);
    tick();
    check("t2_count0", {61'd0, count}, 64'd0);
    check("t2_wb_en_off", {63'd0, wb_en}, 64'd0);

    // Fill under hold, 5th request ignored, then drain in order.
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 64'h11 * i);
    check("t3_count_full", {61'd0, count}, 64'd4);
    check("t3_ready_low", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 64'h99;
    tick();
    in_valid = 1'b0;
    check("t3_fifth_ignored", {61'd0, count}, 64'd4);
    wb_hold = 1'b0;
    #1;
    check("t3_drain_en", {63'd0, wb_en}, 64'd1);
    for (int i = 0; i < 4; i++) tick();
    check("t3_drained", {61'd0, count}, 64'd0);

    // Forwarding picks the youngest match.
    wb_hold = 1'b1;
    push(5'd3, 64'd1);
    push(5'd3, 64'd2);
    look_addr_a = 5'd3;
    look_addr_b = 5'd7;
    #1;
    check("t4_hit_a", {63'd0, hit_a}, 64'd1);
    check("t4_fwd_a", fwd_a, 64'd2);
    check("t4_hit_b", {63'd0, hit_b}, 64'd0);
    check("t4_fwd_b", fwd_b, 64'd0);
    look_addr_b = 5'd0;
    #1;
    check("t4_zero_nohit", {63'd0, hit_b}, 64'd0);
    wb_hold = 1'b0;
    #1;
    check("t4_head_draining_hit", {63'd0, hit_a}, 64'd1);
    tick();
    tick();
    check("t4_drained", {61'd0, count}, 64'd0);
    check("t4_hit_gone", {63'd0, hit_a}, 64'd0);

    // r0 writes are accepted but never enqueued.
    push(5'd0, 64'hFF);
    check("t5_count", {61'd0, count}, 64'd0);
    check("t5_wb_en", {63'd0, wb_en}, 64'd0);
    tick();
    tick();

    // Full buffer refuses a push on the same edge it pops.
    wb_hold = 1'b1;
    for (int i = 10; i <= 13; i++) push(5'(i), 64'hA0 + 64'(i));
    in_valid = 1'b1;
    in_addr  = 5'd14;
    in_data  = 64'hEE;
    wb_hold  = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t6_push_refused", {61'd0, count}, 64'd3);
    for (int i = 0; i < 3; i++) tick();
    check("t6_drained", {61'd0, count}, 64'd0);

    // Wrap: ten back-to-back pushes with concurrent pops.
    for (int i = 1; i <= 10; i++) push(5'(i + 15), 64'h101 * i);
    tick();
    tick();
    check("wrap_drained", {61'd0, count}, 64'd0);

    // Reset with three entries queued discards them.
    wb_hold = 1'b1;
    push(5'd1, 64'h1);
    push(5'd2, 64'h2);
    push(5'd4, 64'h4);
    check("t1_count3", {61'd0, count}, 64'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t1_count0", {61'd0, count}, 64'd0);
    check("t1_wb_en", {63'd0, wb_en}, 64'd0);
    check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    check("t1_wb_addr", {59'd0, wb_addr}, 64'd0);
    wb_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t1_no_writes", {61'd0, count}, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
